// File: rtl/la_pkg.sv
// Shared types and constants for the sequential logic-analyzer trigger.
package la_pkg;

   localparam int DN = 2;
   localparam int DW = 8;
   localparam int SN = 4;
   localparam int CW = 16;
   localparam int SW = $clog2(SN);

   typedef logic [DW-1:0] la_dt_t;

   typedef struct packed {
      la_dt_t        msk;
      la_dt_t        val;
      la_dt_t        pos;
      la_dt_t        neg;
      logic [CW-1:0] cnt;
   } la_trg_cfg_t;

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      DONE
   } la_state_t;

   // A programmed count of zero behaves like a count of one.
   function automatic logic [CW-1:0] la_thr(input logic [CW-1:0] cnt);
      return (cnt == '0) ? CW'(1) : cnt;
   endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// Minimal AXI4-stream bundle carrying DN lanes of DW-bit samples per beat.
interface axi4_stream_if #(
   parameter int DN = 2,
   parameter int DW = 8
) ();

   logic                   TVALID;
   logic                   TREADY;
   logic [DN-1:0][DW-1:0]  TDATA;
   logic [DN-1:0]          TKEEP;
   logic                   TLAST;

   modport d (input TVALID, input TDATA, input TKEEP, input TLAST, output TREADY);
   modport s (output TVALID, output TDATA, output TKEEP, output TLAST, input TREADY);

endinterface

// File: rtl/la_trigger_lane.sv
// Per-lane match vector of one beat against a single stage configuration.
module la_trigger_lane
   import la_pkg::*;
(
   input  la_trg_cfg_t           cfg,
   input  la_dt_t [DN-1:0]       cur,
   input  logic [DN-1:0]         keep,
   input  la_dt_t                prv0,
   input  logic                  prv0_vld,
   output logic [DN-1:0]         match
);

   // Value compare under mask, plus edge terms against the preceding sample.
   function automatic logic lane_hit(input la_dt_t c, input la_dt_t p, input logic pv,
                                     input la_trg_cfg_t cf);
      logic   cmp;
      logic   edg;
      la_dt_t terms;
      cmp   = ((c ^ cf.val) & cf.msk) == '0;
      terms = (~p & c & cf.pos) | (p & ~c & cf.neg);
      if ((cf.pos | cf.neg) == '0) edg = 1'b1;
      else                         edg = pv & (|terms);
      return cmp & edg;
   endfunction

   // Lane 0 looks back across the beat boundary; later lanes look at their lower neighbour.
   always_comb begin
      match    = '0;
      match[0] = keep[0] & lane_hit(cur[0], prv0, prv0_vld, cfg);
      for (int i = 1; i < DN; i++) begin
         match[i] = keep[i] & lane_hit(cur[i], cur[i-1], 1'b1, cfg);
      end
   end

endmodule

// File: rtl/la_trigger_seq.sv
// Multi-stage sequential trigger watching a pass-through AXI4-stream register slice.
module la_trigger_seq
   import la_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ctl_arm,
   input  logic                  ctl_abt,
   input  logic [SW-1:0]         cfg_stg_num,
   input  la_trg_cfg_t [SN-1:0]  cfg_stg,
   output logic                  sts_arm,
   output logic [SW-1:0]         sts_stg,
   output logic                  sts_dne,
   output logic [DN-1:0]         sts_trg,
   axi4_stream_if.d              sti,
   axi4_stream_if.s              sto
);

   la_state_t          state, state_nxt;
   logic [SW-1:0]      stage, stage_nxt, last_stg;
   logic [CW-1:0]      count, count_nxt, thr;
   logic [DN-1:0]      trg_q, trg_nxt, match, hit_lane;
   logic [CW:0]        run;
   logic               hit;
   logic               xfer;
   la_trg_cfg_t        cfg_act;
   la_dt_t             prv, prv_last;
   logic               prv_vld;
   logic               sto_vld;
   la_dt_t [DN-1:0]    sto_data;
   logic [DN-1:0]      sto_keep;
   logic               sto_last;

   assign sti.TREADY = sto.TREADY | ~sto_vld;
   assign xfer       = sti.TVALID & sti.TREADY;

   assign sto.TVALID = sto_vld;
   assign sto.TDATA  = sto_data;
   assign sto.TKEEP  = sto_keep;
   assign sto.TLAST  = sto_last;

   assign sts_arm = (state == ARMED);
   assign sts_dne = (state == DONE);
   assign sts_stg = stage;
   assign sts_trg = trg_q;

   assign cfg_act = cfg_stg[stage];
   assign thr     = la_thr(cfg_act.cnt);

   la_trigger_lane u_lane (
      .cfg      (cfg_act),
      .cur      (sti.TDATA),
      .keep     (sti.TKEEP),
      .prv0     (prv),
      .prv0_vld (prv_vld),
      .match    (match)
   );

   // Out-of-range stage counts fall back to the last physical stage.
   always_comb begin
      if (int'(cfg_stg_num) > SN - 1) last_stg = SW'(SN - 1);
      else                            last_stg = cfg_stg_num;
   end

   // Highest kept lane of the current beat becomes lane 0's predecessor next beat.
   always_comb begin
      prv_last = prv;
      for (int i = 0; i < DN; i++) begin
         if (sti.TKEEP[i]) prv_last = sti.TDATA[i];
      end
   end

   // Walk matches in lane order to find the lane where the occurrence threshold is reached.
   always_comb begin
      run      = {1'b0, count};
      hit      = 1'b0;
      hit_lane = '0;
      for (int i = 0; i < DN; i++) begin
         if (match[i] && !hit) begin
            run = run + (CW+1)'(1);
            if (run >= {1'b0, thr}) begin
               hit         = 1'b1;
               hit_lane[i] = 1'b1;
            end
         end
      end
   end

   // Sequencer next state: abort beats arm, and only transferred beats advance the sequence.
   always_comb begin
      state_nxt = state;
      stage_nxt = stage;
      count_nxt = count;
      trg_nxt   = '0;
      if (ctl_abt) begin
         state_nxt = IDLE;
         stage_nxt = '0;
         count_nxt = '0;
      end else if (ctl_arm) begin
         state_nxt = ARMED;
         stage_nxt = '0;
         count_nxt = '0;
      end else if (state == ARMED && xfer) begin
         if (hit) begin
            if (stage >= last_stg) begin
               state_nxt = DONE;
               trg_nxt   = hit_lane;
            end else begin
               stage_nxt = stage + 1'b1;
               count_nxt = '0;
            end
         end else if (run > {1'b0, {CW{1'b1}}}) begin
            count_nxt = {CW{1'b1}};
         end else begin
            count_nxt = run[CW-1:0];
         end
      end
   end

   // Sequencer state register; the trigger pulse lines up with the beat entering the slice.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         stage <= '0;
         count <= '0;
         trg_q <= '0;
      end else begin
         state <= state_nxt;
         stage <= stage_nxt;
         count <= count_nxt;
         trg_q <= trg_nxt;
      end
   end

   // Sample history tracks every transferred beat regardless of sequencer state.
   always_ff @(posedge clk) begin
      if (rst) begin
         prv     <= '0;
         prv_vld <= 1'b0;
      end else if (xfer && (|sti.TKEEP)) begin
         prv     <= prv_last;
         prv_vld <= 1'b1;
      end
   end

   // One-deep register slice; payload only needs to be valid alongside TVALID.
   always_ff @(posedge clk) begin
      if (rst) begin
         sto_vld <= 1'b0;
      end else if (sti.TREADY) begin
         sto_vld <= sti.TVALID;
      end
      if (xfer) begin
         sto_data <= sti.TDATA;
         sto_keep <= sti.TKEEP;
         sto_last <= sti.TLAST;
      end
   end

endmodule
